dmp_stream_serializer: RTL

Deterministic-order serializer for the gather stage of the pagerank engine. It waits until every enabled hardware thread reports gather-done. It then streams each enabled thread's pagerank vector out in ascending thread-ID order, LANES values per beat, over a valid/ready interface with backpressure. It sits between the per-thread gather units and the apply/commit stage, and it extends the original fixed-width serializer with per-thread masking, multi-beat vectors, flow control and iteration bookkeeping.

---
 rtl/dmp_stream_serializer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dmp_stream_serializer.sv
// Waits for every enabled thread's gather-done, then streams their vectors in ascending thread order, LANES values per beat.
// First beat one cycle after sync, one beat per cycle; a stalled beat holds all outputs until out_ready accepts it.
module dmp_stream_serializer #(
    parameter int NUM_HW_THREADS = 8,
    parameter int NODES_IN_GRAPH = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int LANES          = 8,
    localparam int BEATS = NODES_IN_GRAPH / LANES,
    localparam int TW    = (NUM_HW_THREADS > 1) ? $clog2(NUM_HW_THREADS) : 1,
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                                                      clock,
    input  logic                                                      reset_n,
    input  logic                                                      next_iteration,
    input  logic [NUM_HW_THREADS-1:0][NODES_IN_GRAPH-1:0][DATA_WIDTH-1:0] page_rank_gather,
    input  logic [NUM_HW_THREADS-1:0]                                 done,
    input  logic [NUM_HW_THREADS-1:0]                                 thread_mask,
    output logic                                                      out_valid,
    input  logic                                                      out_ready,
    output logic [LANES-1:0][DATA_WIDTH-1:0]                          out_data,
    output logic [TW-1:0]                                             out_thread_id,
    output logic [BW-1:0]                                             out_beat_idx,
    output logic                                                      out_sop,
    output logic                                                      out_eop,
    output logic                                                      out_last,
    output logic                                                      iteration_done,
    output logic [31:0]                                               iteration_count
);

    localparam int NW = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;

    generate
        if (NODES_IN_GRAPH % LANES != 0) begin : g_lanes_check
            $error("NODES_IN_GRAPH must be a multiple of LANES");
        end
    endgenerate

    typedef enum logic [1:0] {S_WAIT, S_SEND, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [TW-1:0]             thread_q, thread_d;
    logic [BW-1:0]             beat_q, beat_d;
    logic [NUM_HW_THREADS-1:0] mask_q, mask_d;
    logic [31:0]               count_q, count_d;

    logic          sync;
    logic          has_higher;
    logic [TW-1:0] lowest_thr;
    logic [TW-1:0] next_thr;
    logic          send;
    logic          last_beat;

    assign sync      = &(done | ~thread_mask);
    assign send      = (state_q == S_SEND);
    assign last_beat = (beat_q == BW'(BEATS - 1));

    // Lowest enabled thread from the live mask; next enabled thread above the current one from the latched mask.
    always_comb begin
        lowest_thr = '0;
        for (int i = NUM_HW_THREADS - 1; i >= 0; i--) begin
            if (thread_mask[i]) lowest_thr = TW'(i);
        end
        has_higher = 1'b0;
        next_thr   = '0;
        for (int i = NUM_HW_THREADS - 1; i >= 0; i--) begin
            if (mask_q[i] && (TW'(i) > thread_q)) begin
                has_higher = 1'b1;
                next_thr   = TW'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        thread_d = thread_q;
        beat_d   = beat_q;
        mask_d   = mask_q;
        count_d  = count_q;
        case (state_q)
            S_WAIT: begin
                if (thread_mask == '0) begin
                    state_d = S_DONE;
                    mask_d  = '0;
                    count_d = count_q + 32'd1;
                end else if (sync) begin
                    state_d  = S_SEND;
                    mask_d   = thread_mask;
                    thread_d = lowest_thr;
                    beat_d   = '0;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    if (!last_beat) begin
                        beat_d = beat_q + BW'(1);
                    end else if (has_higher) begin
                        beat_d   = '0;
                        thread_d = next_thr;
                    end else begin
                        beat_d   = '0;
                        thread_d = '0;
                        state_d  = S_DONE;
                        count_d  = count_q + 32'd1;
                    end
                end
            end
            S_DONE: begin
                if (next_iteration) state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_WAIT;
            thread_q <= '0;
            beat_q   <= '0;
            mask_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            thread_q <= thread_d;
            beat_q   <= beat_d;
            mask_q   <= mask_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        out_data = '0;
        if (send) begin
            for (int k = 0; k < LANES; k++) begin
                out_data[k] = page_rank_gather[thread_q][NW'(beat_q) * NW'(LANES) + NW'(k)];
            end
        end
    end

    assign out_valid       = send;
    assign out_thread_id   = send ? thread_q : '0;
    assign out_beat_idx    = send ? beat_q : '0;
    assign out_sop         = send && (beat_q == '0);
    assign out_eop         = send && last_beat;
    assign out_last        = send && last_beat && !has_higher;
    assign iteration_done  = (state_q == S_DONE);
    assign iteration_count = count_q;

endmodule
